fifo_rd_stream: RTL and testbench



---
 rtl/fifo_rd_stream_buf.sv | 61 ++++++
 rtl/fifo_rd_stream.sv | 86 ++++++++
 tb/tb_fifo_rd_stream.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/fifo_rd_stream_buf.sv
// fifo_rd_stream_buf: BUF_DEPTH-entry synchronous skid buffer.
// Push writes at wr_ptr; pop advances rd_ptr. The pointers wrap
// naturally because BUF_DEPTH is a power of two. The head word is
// read combinationally so it is visible in the cycle after the push.
module fifo_rd_stream_buf #(
  parameter int DATA_WIDTH = 32,
  parameter int BUF_DEPTH  = 2,
  parameter int ADDR_WIDTH = $clog2(BUF_DEPTH),
  parameter int CNT_WIDTH  = ADDR_WIDTH + 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_push,
  input  logic [DATA_WIDTH-1:0] i_push_data,
  input  logic                  i_pop,
  output logic [DATA_WIDTH-1:0] o_head,
  output logic [CNT_WIDTH-1:0]  o_cnt
);

  logic [DATA_WIDTH-1:0] r_mem [BUF_DEPTH];
  logic [ADDR_WIDTH-1:0] r_wr_ptr;
  logic [ADDR_WIDTH-1:0] r_rd_ptr;
  logic [CNT_WIDTH-1:0]  r_cnt;

  // Write side: store the returned FIFO word and advance the write pointer.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_mem    <= '{default: '0};
      r_wr_ptr <= '0;
    end else if (i_push) begin
      r_mem[r_wr_ptr] <= i_push_data;
      r_wr_ptr        <= r_wr_ptr + 1'b1;
    end
  end

  // Read side: advance the read pointer on each accepted stream word.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rd_ptr <= '0;
    end else if (i_pop) begin
      r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // Occupancy: simultaneous push and pop leaves the count unchanged.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else begin
      case ({i_push, i_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  assign o_head = r_mem[r_rd_ptr];
  assign o_cnt  = r_cnt;

endmodule

// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream: read-side adapter that turns a FIFO read port
// (rd_en / rd_data one cycle later / empty) into a valid/ready stream
// at one word per cycle, through a small skid buffer.
// Optional feature macro: FIFO_RD_STREAM_CNT_EN adds o_word_cnt, a
// 32-bit wrapping count of delivered words cleared by i_rst.
module fifo_rd_stream #(
  parameter int DATA_WIDTH = 32,
  parameter int BUF_DEPTH  = 2,
  parameter int ADDR_WIDTH = $clog2(BUF_DEPTH),
  parameter int CNT_WIDTH  = ADDR_WIDTH + 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  output logic                  o_fifo_rd_en,
  input  logic                  i_fifo_empty,
  input  logic [DATA_WIDTH-1:0] i_fifo_rd_data,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic [CNT_WIDTH-1:0]  o_level
`ifdef FIFO_RD_STREAM_CNT_EN
  ,
  output logic [31:0]           o_word_cnt
`endif
);

  localparam logic [CNT_WIDTH:0] DEPTH_L = (CNT_WIDTH + 1)'(BUF_DEPTH);

  logic                 r_inflight;
  logic                 w_pop;
  logic [CNT_WIDTH-1:0] w_cnt;
  logic [CNT_WIDTH:0]   w_need;

  fifo_rd_stream_buf #(
    .DATA_WIDTH (DATA_WIDTH),
    .BUF_DEPTH  (BUF_DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .CNT_WIDTH  (CNT_WIDTH)
  ) u_buf (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_push      (r_inflight),
    .i_push_data (i_fifo_rd_data),
    .i_pop       (w_pop),
    .o_head      (o_data),
    .o_cnt       (w_cnt)
  );

  assign o_valid = (w_cnt != '0);
  assign o_level = w_cnt;
  assign w_pop   = o_valid && i_ready;

  // Issue rule: reserve a buffer slot for every in-flight word, crediting
  // the pop happening this cycle so a full buffer refills back-to-back.
  always_comb begin
    w_need = {1'b0, w_cnt}
           + {{CNT_WIDTH{1'b0}}, r_inflight}
           - {{CNT_WIDTH{1'b0}}, w_pop};
    o_fifo_rd_en = !i_rst && !i_fifo_empty && (w_need < DEPTH_L);
  end

  // A read accepted this cycle returns data next cycle; remember that.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= o_fifo_rd_en;
    end
  end

`ifdef FIFO_RD_STREAM_CNT_EN
  logic [31:0] r_word_cnt;

  // Delivered-word counter, wraps at 2^32.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_word_cnt <= '0;
    end else if (w_pop) begin
      r_word_cnt <= r_word_cnt + 32'd1;
    end
  end

  assign o_word_cnt = r_word_cnt;
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// tb_fifo_rd_stream: drives fifo_rd_stream from a behavioural FIFO model
// (queue with registered read data) and checks the stream side against
// per-cycle vector tables and a data scoreboard.
module tb_fifo_rd_stream;

  localparam int DW = 32;
  localparam int CW = 2;

  logic          i_clk;
  logic          i_rst;
  logic          o_fifo_rd_en;
  logic          i_fifo_empty;
  logic [DW-1:0] i_fifo_rd_data;
  logic          o_valid;
  logic          i_ready;
  logic [DW-1:0] o_data;
  logic [CW-1:0] o_level;
`ifdef FIFO_RD_STREAM_CNT_EN
  logic [31:0]   o_word_cnt;
`endif

  fifo_rd_stream #(
    .DATA_WIDTH (DW),
    .BUF_DEPTH  (2)
  ) dut (
    .i_clk          (i_clk),
    .i_rst          (i_rst),
    .o_fifo_rd_en   (o_fifo_rd_en),
    .i_fifo_empty   (i_fifo_empty),
    .i_fifo_rd_data (i_fifo_rd_data),
    .o_valid        (o_valid),
    .i_ready        (i_ready),
    .o_data         (o_data),
    .o_level        (o_level)
`ifdef FIFO_RD_STREAM_CNT_EN
    ,
    .o_word_cnt     (o_word_cnt)
`endif
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  typedef struct {
    logic       rdy;
    logic       rd_en;
    logic       valid;
    logic [2:0] level;
  } vec_t;

  int unsigned total = 0;
  int unsigned bad   = 0;

  logic [DW-1:0] fq[$];     // upstream FIFO contents
  logic [DW-1:0] exp_q[$];  // words handed to the DUT, in order
  int            reads;
  int            delivered;
  logic          last_rd_en;
  logic          last_valid;
  logic [2:0]    last_level;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock cycle, entered and left 1 time unit after a rising edge.
  task automatic cycle(input logic rdy, input logic hold_empty);
    logic [DW-1:0] e;
    i_ready      = rdy;
    i_fifo_empty = hold_empty || (fq.size() == 0);
    #4;
    last_rd_en = o_fifo_rd_en;
    last_valid = o_valid;
    last_level = 3'(o_level);
    if (o_valid && i_ready) begin
      delivered++;
      if (exp_q.size() == 0) begin
        chk("sb_underrun", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("sb_data", o_data, e);
      end
    end
    if (o_fifo_rd_en) reads++;
    @(posedge i_clk);
    #1;
    if (last_rd_en) begin
      if (fq.size() == 0) begin
        chk("fifo_underrun", 32'd1, 32'd0);
      end else begin
        i_fifo_rd_data = fq.pop_front();
        exp_q.push_back(i_fifo_rd_data);
      end
    end
  endtask

  task automatic apply_vec(input string tag, input vec_t v);
    cycle(v.rdy, 1'b0);
    chk({tag, "_rd_en"}, 32'(last_rd_en), 32'(v.rd_en));
    chk({tag, "_valid"}, 32'(last_valid), 32'(v.valid));
    chk({tag, "_level"}, 32'(last_level), 32'(v.level));
  endtask

  vec_t single_tab[4];
  vec_t bp_tab[8];

  initial begin
    single_tab[0] = '{1'b1, 1'b1, 1'b0, 3'd0};
    single_tab[1] = '{1'b1, 1'b0, 1'b0, 3'd0};
    single_tab[2] = '{1'b1, 1'b0, 1'b1, 3'd1};
    single_tab[3] = '{1'b1, 1'b0, 1'b0, 3'd0};

    bp_tab[0] = '{1'b0, 1'b1, 1'b0, 3'd0};
    bp_tab[1] = '{1'b0, 1'b1, 1'b0, 3'd0};
    bp_tab[2] = '{1'b0, 1'b0, 1'b1, 3'd1};
    bp_tab[3] = '{1'b0, 1'b0, 1'b1, 3'd2};
    bp_tab[4] = '{1'b0, 1'b0, 1'b1, 3'd2};
    bp_tab[5] = '{1'b0, 1'b0, 1'b1, 3'd2};
    bp_tab[6] = '{1'b1, 1'b1, 1'b1, 3'd2};  // pop and refill in the same cycle
    bp_tab[7] = '{1'b1, 1'b1, 1'b1, 3'd1};

    i_rst          = 1'b1;
    i_ready        = 1'b0;
    i_fifo_empty   = 1'b0;
    i_fifo_rd_data = '0;
    reads          = 0;
    delivered      = 0;
    @(posedge i_clk);
    #1;

    // Reset held with a non-empty FIFO: nothing issued, nothing valid.
    fq = '{32'h1111_0000, 32'h1111_0001, 32'h1111_0002};
    for (int k = 0; k < 3; k++) begin
      cycle(1'b1, 1'b0);
      chk("rst_rd_en", 32'(last_rd_en), 32'd0);
      chk("rst_valid", 32'(last_valid), 32'd0);
      chk("rst_level", 32'(last_level), 32'd0);
    end
    chk("rst_data", o_data, 32'd0);
    i_rst = 1'b0;
    fq.delete();
    exp_q.delete();

    // Single word.
    fq.push_back(32'hA5A5_0001);
    delivered = 0;
    for (int k = 0; k < 4; k++) apply_vec("single", single_tab[k]);
    chk("single_delivered", 32'(delivered), 32'd1);

    // Streaming 16 words: 16 back-to-back reads, 16 back-to-back valids.
    for (int k = 0; k < 16; k++) fq.push_back(32'(k));
    reads = 0;
    delivered = 0;
    for (int k = 0; k < 20; k++) begin
      cycle(1'b1, 1'b0);
      chk("stream_rd_en", 32'(last_rd_en), 32'(k < 16));
      chk("stream_valid", 32'(last_valid), 32'((k >= 2) && (k < 18)));
    end
    chk("stream_reads", 32'(reads), 32'd16);
    chk("stream_delivered", 32'(delivered), 32'd16);

    // Backpressure: only two reads while stalled, head word held.
    for (int k = 0; k < 8; k++) fq.push_back(32'hB000_0000 + 32'(k));
    reads = 0;
    delivered = 0;
    for (int k = 0; k < 8; k++) begin
      apply_vec("bp", bp_tab[k]);
      if (k >= 2 && k < 6) chk("bp_hold_data", o_data, 32'hB000_0000);
      if (k == 5) chk("bp_reads_stalled", 32'(reads), 32'd2);
    end
    for (int k = 0; k < 10; k++) cycle(1'b1, 1'b0);
    chk("bp_delivered", 32'(delivered), 32'd8);
    chk("bp_reads", 32'(reads), 32'd8);
    chk("bp_valid_end", 32'(last_valid), 32'd0);

    // FIFO empties after three words.
    for (int k = 0; k < 6; k++) fq.push_back(32'hC000_0000 + 32'(k));
    reads = 0;
    delivered = 0;
    for (int k = 0; k < 10; k++) cycle(1'b1, reads >= 3);
    chk("mid_reads", 32'(reads), 32'd3);
    chk("mid_delivered", 32'(delivered), 32'd3);
    chk("mid_valid_end", 32'(last_valid), 32'd0);
    chk("mid_level_end", 32'(last_level), 32'd0);
    fq.delete();

    // Reset while a word is in flight: it must be dropped.
    fq = '{32'hD000_0000, 32'hD000_0001, 32'hD000_0002};
    cycle(1'b1, 1'b0);
    chk("rif_rd_en", 32'(last_rd_en), 32'd1);
    i_rst = 1'b1;
    cycle(1'b1, 1'b0);
    chk("rif_rd_en_rst", 32'(last_rd_en), 32'd0);
    i_rst = 1'b0;
    fq.delete();
    exp_q.delete();
    delivered = 0;
    cycle(1'b1, 1'b0);
    chk("rif_level", 32'(last_level), 32'd0);
    chk("rif_valid", 32'(last_valid), 32'd0);
`ifdef FIFO_RD_STREAM_CNT_EN
    chk("rif_word_cnt", o_word_cnt, 32'd0);
`endif
    cycle(1'b1, 1'b0);
    chk("rif_delivered", 32'(delivered), 32'd0);

    chk("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
